// File: rtl/mem_access.sv
// Memory-stage data access: drives a wait-state data bus, aligns load data,
// and stalls the upstream pipeline until the bus transaction finishes.
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [1:0]  MemSize_MEM,
    input  logic        MemSigned_MEM,
    input  logic [31:0] AluResult_MEM,
    input  logic [31:0] WriteData_MEM,
    input  logic        regWr_in,
    output logic        regWr_MEM,
    output logic [31:0] ReadMemData_MEM,
    output logic        stall_MEM,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;

    logic        access;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        go;
    logic [1:0]  lane;
    logic [31:0] sh;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;

    assign lane       = AluResult_MEM[1:0];
    assign access     = MemRead_MEM | MemWrite_MEM;
    assign is_byte    = (MemSize_MEM == 2'b00);
    assign is_half    = (MemSize_MEM == 2'b01);
    assign misaligned = (is_half & lane[0])
                      | (!is_byte & !is_half & (lane != 2'b00));
    assign go         = access & !misaligned;

    always_comb begin
        sh      = mem_rdata >> {lane, 3'b000};
        be_c    = 4'b1111;
        wdata_c = WriteData_MEM;
        load_c  = mem_rdata;
        if (is_byte) begin
            be_c    = 4'b0001 << lane;
            wdata_c = {4{WriteData_MEM[7:0]}};
            load_c  = {{24{MemSigned_MEM & sh[7]}}, sh[7:0]};
        end else if (is_half) begin
            be_c    = 4'b0011 << lane;
            wdata_c = {2{WriteData_MEM[15:0]}};
            load_c  = {{16{MemSigned_MEM & sh[15]}}, sh[15:0]};
        end
    end

    // Gated by rst_n so the pipeline is released the moment reset asserts.
    assign stall_MEM = rst_n & (((state == IDLE) & go) | (state == REQ));
    assign misalign_err = rst_n & (state == IDLE) & access & misaligned;
    assign regWr_MEM = regWr_in & !stall_MEM & !misalign_err & !bus_err;
    assign ReadMemData_MEM = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata_q   <= '0;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state     <= REQ;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_MEM;
                        mem_addr  <= {AluResult_MEM[31:2], 2'b00};
                        mem_be    <= be_c;
                        mem_wdata <= wdata_c;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_we) rdata_q <= load_c;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized and directed bench for mem_access against a behavioural
// bus/pipeline model; uses TIMEOUT=4 to reach the abort path quickly.
module tb_mem_access;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic [1:0]  MemSize_MEM;
    logic        MemSigned_MEM;
    logic [31:0] AluResult_MEM;
    logic [31:0] WriteData_MEM;
    logic        regWr_in;
    logic        regWr_MEM;
    logic [31:0] ReadMemData_MEM;
    logic        stall_MEM;
    logic        misalign_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rd = 32'h0;

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .MemRead_MEM(MemRead_MEM),
        .MemWrite_MEM(MemWrite_MEM),
        .MemSize_MEM(MemSize_MEM),
        .MemSigned_MEM(MemSigned_MEM),
        .AluResult_MEM(AluResult_MEM),
        .WriteData_MEM(WriteData_MEM),
        .regWr_in(regWr_in),
        .regWr_MEM(regWr_MEM),
        .ReadMemData_MEM(ReadMemData_MEM),
        .stall_MEM(stall_MEM),
        .misalign_err(misalign_err),
        .bus_err(bus_err),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        MemRead_MEM   = 1'b0;
        MemWrite_MEM  = 1'b0;
        MemSize_MEM   = 2'b10;
        MemSigned_MEM = 1'b0;
        AluResult_MEM = 32'h0;
        WriteData_MEM = 32'h0;
        regWr_in      = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'h0;
    endtask

    // One instruction in MEM from presentation until the pipeline moves on.
    task automatic run_access(input bit rd, input bit wr, input logic [1:0] sz,
                              input bit sg, input logic [31:0] ad,
                              input logic [31:0] wd, input logic [31:0] rdat,
                              input int waits, input bit rw, input string nm);
        int nb;
        int lane;
        bit mis;
        bit acc;
        bit tout;
        logic [63:0] m;
        logic [31:0] ewd;
        logic [31:0] eld;
        logic [3:0]  ebe;
        int ecyc;
        int ereq;
        int cyc;
        int reqc;
        int stc;
        bit fin;
        nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        lane = int'(ad[1:0]);
        acc  = rd | wr;
        mis  = acc && ((lane % nb) != 0);
        tout = waits >= TMO;
        m    = (64'd1 << (8 * nb)) - 64'd1;
        ebe  = 4'(((1 << nb) - 1) << lane);
        ewd  = 32'h0;
        for (int i = 0; i < 4; i += nb)
            ewd = ewd | 32'((64'(wd) & m) << (8 * i));
        eld = 32'((64'(rdat) >> (8 * lane)) & m);
        if (nb < 4 && sg && ((eld >> (8 * nb - 1)) & 32'h1) != 0)
            eld = eld | ~32'(m);
        ecyc = tout ? TMO + 2 : waits + 3;
        ereq = tout ? TMO : waits + 1;

        MemRead_MEM   = rd;
        MemWrite_MEM  = wr;
        MemSize_MEM   = sz;
        MemSigned_MEM = sg;
        AluResult_MEM = ad;
        WriteData_MEM = wd;
        regWr_in      = rw;
        #1;

        if (!acc || mis) begin
            checks++;
            if (stall_MEM !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s nostall: stall=%b req=%b want 0 0",
                         nm, stall_MEM, mem_req);
            end
            checks++;
            if (misalign_err !== mis) begin
                errors++;
                $display("FAIL %s misalign_err: got %b want %b",
                         nm, misalign_err, mis);
            end
            checks++;
            if (regWr_MEM !== (rw && !mis)) begin
                errors++;
                $display("FAIL %s regWr: got %b want %b",
                         nm, regWr_MEM, rw && !mis);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s req_after: got %b want 0", nm, mem_req);
            end
            set_idle();
            return;
        end

        if (tout) exp_rd = 32'h0;
        else if (rd) exp_rd = eld;

        cyc  = 0;
        reqc = 0;
        stc  = 0;
        fin  = 1'b0;
        while (!fin && cyc < 40) begin
            if (cyc == 0) begin
                checks++;
                if (stall_MEM !== 1'b1 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s first: stall=%b req=%b want 1 0",
                             nm, stall_MEM, mem_req);
                end
            end
            if (stall_MEM === 1'b1) begin
                stc++;
                checks++;
                if (regWr_MEM !== 1'b0) begin
                    errors++;
                    $display("FAIL %s regWr_stall: got %b want 0",
                             nm, regWr_MEM);
                end
            end
            if (mem_req === 1'b1) begin
                reqc++;
                checks++;
                if (mem_we !== wr || mem_be !== ebe ||
                    mem_addr !== {ad[31:2], 2'b00} || mem_wdata !== ewd) begin
                    errors++;
                    $display("FAIL %s bus: we=%b be=%b a=%h wd=%h want %b %b %h %h",
                             nm, mem_we, mem_be, mem_addr, mem_wdata,
                             wr, ebe, {ad[31:2], 2'b00}, ewd);
                end
                mem_ack   = (reqc == waits + 1);
                mem_rdata = mem_ack ? rdat : $urandom;
            end else begin
                mem_ack   = 1'($urandom);
                mem_rdata = $urandom;
            end
            if (cyc > 0 && stall_MEM !== 1'b1) begin
                fin = 1'b1;
                checks++;
                if (ReadMemData_MEM !== exp_rd) begin
                    errors++;
                    $display("FAIL %s rdata: got %h want %h",
                             nm, ReadMemData_MEM, exp_rd);
                end
                checks++;
                if (bus_err !== tout || regWr_MEM !== (rw && !tout)) begin
                    errors++;
                    $display("FAIL %s done: bus_err=%b regWr=%b want %b %b",
                             nm, bus_err, regWr_MEM, tout, rw && !tout);
                end
                checks++;
                if (cyc + 1 != ecyc || stc != ecyc - 1 || reqc != ereq) begin
                    errors++;
                    $display("FAIL %s timing: cyc=%0d stall=%0d req=%0d want %0d %0d %0d",
                             nm, cyc + 1, stc, reqc, ecyc, ecyc - 1, ereq);
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!fin) begin
            errors++;
            checks++;
            $display("FAIL %s hang: no completion within 40 cycles", nm);
        end
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL %s bus_err_pulse: got %b want 0", nm, bus_err);
        end
        set_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        MemRead_MEM = 1'b1;
        regWr_in    = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall_MEM !== 1'b0 || mem_be !== 4'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: req=%b stall=%b be=%h a=%h wd=%h we=%b want zeros",
                     mem_req, stall_MEM, mem_be, mem_addr, mem_wdata, mem_we);
        end
        checks++;
        if (ReadMemData_MEM !== 32'h0 || bus_err !== 1'b0 ||
            misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: rd=%h be=%b me=%b want 0 0 0",
                     ReadMemData_MEM, bus_err, misalign_err);
        end
        set_idle();
        rst_n = 1'b1;
        @(negedge clk);
        exp_rd = 32'h0;
    endtask

    task automatic test_directed();
        run_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, "lw0");
        run_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FFFFFF, 3, 1, "lbs");
        run_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FFFFFF, 3, 1, "lbu");
        run_access(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0, 2, 0, "sh");
        run_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 1, "lw_mis");
        run_access(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 0, 1, "nomem");
        run_access(1, 0, 2'b11, 0, 32'h40, 32'h0, 32'h12345678, 1, 1, "lres");
        run_access(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h0, 99, 1, "tmo");
        run_access(1, 0, 2'b01, 1, 32'h302, 32'h0, 32'h8001_7FFF, 0, 1, "lhs");
    endtask

    task automatic test_reset_mid();
        MemRead_MEM   = 1'b1;
        MemSize_MEM   = 2'b10;
        AluResult_MEM = 32'h400;
        regWr_in      = 1'b1;
        mem_ack       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: got %b want 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall_MEM !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: req=%b stall=%b be=%b want 0 0 0",
                     mem_req, stall_MEM, bus_err);
        end
        set_idle();
        @(negedge clk);
        rst_n  = 1'b1;
        exp_rd = 32'h0;
        @(negedge clk);
        run_access(1, 0, 2'b00, 1, 32'h405, 32'h0, 32'h0000F700, 1, 1, "after_rst");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int k;
            k = int'($urandom_range(0, 2));
            run_access(k == 0, k == 1, 2'($urandom), 1'($urandom), $urandom,
                       $urandom, $urandom, int'($urandom_range(0, 5)),
                       1'($urandom), "rand");
        end
    endtask

    task automatic test_back_to_back();
        run_access(0, 1, 2'b00, 0, 32'h501, 32'h000000A5, 32'h0, 0, 0, "b2b_sb");
        run_access(1, 0, 2'b00, 0, 32'h501, 32'h0, 32'h0000A500, 0, 1, "b2b_lb");
        run_access(1, 0, 2'b01, 0, 32'h502, 32'h0, 32'hBEEF0000, 0, 1, "b2b_lh");
    endtask

    initial begin
        set_idle();
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage data-access unit of the 5-stage MIPS pipeline. It sits between the EX/MEM register and the MEM/WB register. It turns load/store control from EX/MEM into transactions on a wait-state-capable data bus. It also aligns and extends load data into ReadMemData_MEM, stalls the upstream pipeline until the bus completes, and bubbles the register-write enable toward MEM/WB while stalled.

## Interface
- TIMEOUT, 16: maximum cycles mem_req may stay high without mem_ack before abort (≥2).
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead_MEM  in  1  load in MEM stage.
- MemWrite_MEM  in  1  store in MEM stage (never both with MemRead_MEM).
- MemSize_MEM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- MemSigned_MEM  in  1  1 = sign-extend loads, 0 = zero-extend.
- AluResult_MEM  in  32  effective address.
- WriteData_MEM  in  32  store data, right-aligned.
- regWr_in  in  1  register-write enable from EX/MEM.
- regWr_MEM  out  1  register-write enable to MEM/WB; forced 0 while stall_MEM=1 or on error.
- ReadMemData_MEM  out  32  aligned, extended load data.
- stall_MEM  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- misalign_err  out  1  one-cycle pulse on misaligned access.
- bus_err  out  1  one-cycle pulse on timeout abort.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address {AluResult_MEM[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  bus read data, valid with mem_ack.
- mem_ack  in  1  completion, sampled only while mem_req=1.

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - No access, or misaligned access: stall_MEM=0, mem_req stays 0.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠00. It raises misalign_err for that cycle and forces regWr_MEM=0.
  - Aligned load/store: stall_MEM=1 combinationally; next state REQ; mem_req←1, timeout counter←0.
- REQ:
  - stall_MEM=1, mem_req=1.
  - mem_ack=1 at the edge: a load captures the formatted mem_rdata into the data register; mem_req←0; next state DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without ack: mem_req←0, data register←0, bus_err pulses in DONE, and regWr_MEM=0 in DONE.
- DONE:
  - stall_MEM=0; the pipeline advances at this edge; next state IDLE.
  - The instruction now in MEM is not re-issued: DONE→IDLE, so an access is seen only in IDLE. Consecutive memory instructions each pay the full sequence.
- Byte lanes (little-endian, lane = addr[1:0]):
  - Byte: be = 0001<<lane, wdata = {4{wd[7:0]}}.
  - Half: be = 0011<<lane, wdata = {2{wd[15:0]}}.
  - Word: be = 1111, wdata = wd.
- Load formatting:
  - Select the byte or half at the lane from mem_rdata.
  - Sign-extend when MemSigned_MEM=1, else zero-extend. Word loads pass through.
- mem_we, mem_addr, mem_be, mem_wdata are registered with mem_req and held constant throughout REQ.
- ReadMemData_MEM always shows the data register, which holds until the next load capture or abort.
- Non-memory instructions pass regWr_in through unchanged.

## Timing
- Reset (async, immediate) values:
  - state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata = 0; data register=0; counter=0.
  - stall_MEM, misalign_err, bus_err = 0. regWr_MEM follows the combinational rule and is 0 when regWr_in=0.
- Access latency: cycle 0 IDLE (stall), cycle 1+ REQ, ack in cycle k → DONE in k+1.
  - Zero-wait bus: 3 cycles total, 2 stall cycles.
  - N wait cycles: 3+N cycles.
- mem_ack outside REQ is ignored. mem_ack coinciding with the timeout limit counts as success.
- Reset mid-REQ drops mem_req asynchronously, with no completion and no error pulse.
- Error pulses are exactly one cycle. regWr_MEM=0 in every stall cycle.

## Test plan
- Word load, addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF → stall_MEM high 2 cycles, mem_be=1111, ReadMemData_MEM=0xDEADBEEF in DONE, regWr_MEM=1 only in DONE.
- Signed byte load, addr 0x103, rdata 0x80FFFFFF, 3 wait cycles → mem_be=1000, ReadMemData_MEM=0xFFFFFF80, total 6 cycles; unsigned repeat gives 0x00000080.
- Half store, addr 0x202, data 0x0000ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, held stable across wait states.
- Word load at addr 0x101 → no mem_req, stall_MEM=0, misalign_err 1-cycle pulse, regWr_MEM=0.
- TIMEOUT=4, no ack → mem_req high exactly 4 cycles, then bus_err pulse, ReadMemData_MEM=0, pipeline released.
- rst_n low during REQ with wait states → mem_req, stall_MEM drop immediately; after release a new load completes normally.
